// File: rtl/avalon_mem_if_arb2.sv
// Two-way round-robin arbiter sharing one Avalon-MM memory port between two requesters.
// Write bursts hold the grant until their final beat; read responses are steered by an in-order tag FIFO.
module avalon_mem_if_arb2 #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int MAX_READS       = 16
) (
  input  logic                       clk,
  input  logic                       reset,

  output logic [ADDR_WIDTH-1:0]      mem_fiu_address,
  output logic [BURST_CNT_WIDTH-1:0] mem_fiu_burstcount,
  output logic [DATA_WIDTH-1:0]      mem_fiu_writedata,
  output logic [DATA_WIDTH/8-1:0]    mem_fiu_byteenable,
  output logic                       mem_fiu_read,
  output logic                       mem_fiu_write,
  input  logic                       mem_fiu_waitrequest,
  input  logic [DATA_WIDTH-1:0]      mem_fiu_readdata,
  input  logic                       mem_fiu_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]      mem_afu0_address,
  input  logic [BURST_CNT_WIDTH-1:0] mem_afu0_burstcount,
  input  logic [DATA_WIDTH-1:0]      mem_afu0_writedata,
  input  logic [DATA_WIDTH/8-1:0]    mem_afu0_byteenable,
  input  logic                       mem_afu0_read,
  input  logic                       mem_afu0_write,
  output logic                       mem_afu0_waitrequest,
  output logic [DATA_WIDTH-1:0]      mem_afu0_readdata,
  output logic                       mem_afu0_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]      mem_afu1_address,
  input  logic [BURST_CNT_WIDTH-1:0] mem_afu1_burstcount,
  input  logic [DATA_WIDTH-1:0]      mem_afu1_writedata,
  input  logic [DATA_WIDTH/8-1:0]    mem_afu1_byteenable,
  input  logic                       mem_afu1_read,
  input  logic                       mem_afu1_write,
  output logic                       mem_afu1_waitrequest,
  output logic [DATA_WIDTH-1:0]      mem_afu1_readdata,
  output logic                       mem_afu1_readdatavalid
);

  localparam int PTR_W = $clog2(MAX_READS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {GRANT_ARB, WR_LOCK} state_t;

  state_t                     state;
  logic                       owner;
  logic                       last;
  logic [BURST_CNT_WIDTH-1:0] beats_left;
  logic                       hold_valid;
  logic                       hold_id;

  logic [MAX_READS-1:0]       fifo_id;
  logic [BURST_CNT_WIDTH-1:0] fifo_bc [MAX_READS];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           fifo_count;
  logic [BURST_CNT_WIDTH-1:0] beat_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       head_id;
  logic [BURST_CNT_WIDTH-1:0] head_bc;

  logic                       cand0;
  logic                       cand1;
  logic                       gnt_valid;
  logic                       gnt_id;
  logic                       fiu_accept;
  logic                       push;
  logic                       rsp_valid;
  logic                       pop;

  assign fifo_full  = (fifo_count == CNT_W'(MAX_READS));
  assign fifo_empty = (fifo_count == '0);
  assign head_id    = fifo_id[rd_ptr];
  assign head_bc    = fifo_bc[rd_ptr];

  // A stalled grant is pinned by hold_* so a late-arriving rival cannot steal it mid-handshake.
  always_comb begin
    cand0     = mem_afu0_write | (mem_afu0_read & ~fifo_full);
    cand1     = mem_afu1_write | (mem_afu1_read & ~fifo_full);
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (reset) begin
      gnt_valid = 1'b0;
    end else if (state == WR_LOCK) begin
      gnt_valid = 1'b1;
      gnt_id    = owner;
    end else if (hold_valid && (hold_id ? cand1 : cand0)) begin
      gnt_valid = 1'b1;
      gnt_id    = hold_id;
    end else if (cand0 && cand1) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last;
    end else if (cand0 || cand1) begin
      gnt_valid = 1'b1;
      gnt_id    = cand1;
    end
  end

  always_comb begin
    mem_fiu_address    = gnt_id ? mem_afu1_address    : mem_afu0_address;
    mem_fiu_burstcount = gnt_id ? mem_afu1_burstcount : mem_afu0_burstcount;
    mem_fiu_writedata  = gnt_id ? mem_afu1_writedata  : mem_afu0_writedata;
    mem_fiu_byteenable = gnt_id ? mem_afu1_byteenable : mem_afu0_byteenable;
    mem_fiu_write      = gnt_valid & (gnt_id ? mem_afu1_write : mem_afu0_write);
    mem_fiu_read       = gnt_valid & (state == GRANT_ARB) & ~fifo_full &
                         (gnt_id ? mem_afu1_read : mem_afu0_read);
  end

  assign fiu_accept = (mem_fiu_read | mem_fiu_write) & ~mem_fiu_waitrequest;
  assign push       = mem_fiu_read & ~mem_fiu_waitrequest;
  assign rsp_valid  = mem_fiu_readdatavalid & ~fifo_empty & ~reset;
  assign pop        = rsp_valid & (beat_cnt == head_bc - BURST_CNT_WIDTH'(1));

  assign mem_afu0_waitrequest   = ~(fiu_accept & ~gnt_id);
  assign mem_afu1_waitrequest   = ~(fiu_accept & gnt_id);
  assign mem_afu0_readdata      = mem_fiu_readdata;
  assign mem_afu1_readdata      = mem_fiu_readdata;
  assign mem_afu0_readdatavalid = rsp_valid & ~head_id;
  assign mem_afu1_readdatavalid = rsp_valid & head_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GRANT_ARB;
      owner      <= 1'b0;
      last       <= 1'b1;
      beats_left <= '0;
      hold_valid <= 1'b0;
      hold_id    <= 1'b0;
    end else begin
      case (state)
        GRANT_ARB: begin
          if (fiu_accept) begin
            last       <= gnt_id;
            hold_valid <= 1'b0;
            if (mem_fiu_write && (mem_fiu_burstcount > BURST_CNT_WIDTH'(1))) begin
              state      <= WR_LOCK;
              owner      <= gnt_id;
              beats_left <= mem_fiu_burstcount - BURST_CNT_WIDTH'(1);
            end
          end else if (gnt_valid && mem_fiu_waitrequest) begin
            hold_valid <= 1'b1;
            hold_id    <= gnt_id;
          end else begin
            hold_valid <= 1'b0;
          end
        end
        WR_LOCK: begin
          if (fiu_accept) begin
            beats_left <= beats_left - BURST_CNT_WIDTH'(1);
            if (beats_left == BURST_CNT_WIDTH'(1)) state <= GRANT_ARB;
          end
        end
        default: state <= GRANT_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      beat_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (pop)            beat_cnt <= '0;
      else if (rsp_valid) beat_cnt <= beat_cnt + BURST_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= gnt_id;
      fifo_bc[wr_ptr] <= mem_fiu_burstcount;
    end
  end

  a_no_read_in_lock: assert property (@(posedge clk) disable iff (reset)
    !(state == WR_LOCK && (owner ? mem_afu1_read : mem_afu0_read)));
  a_no_orphan_rdv: assert property (@(posedge clk) disable iff (reset)
    !(mem_fiu_readdatavalid && fifo_empty));
  a_no_zero_burst: assert property (@(posedge clk) disable iff (reset)
    !(fiu_accept && mem_fiu_burstcount == '0));

endmodule

// File: tb/tb_avalon_mem_if_arb2.sv
// Bench for avalon_mem_if_arb2: transaction-level requesters, a behavioural memory and
// per-requester expected-read queues, driven by directed steps followed by random traffic.
module tb_avalon_mem_if_arb2;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int MR = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]   mem_fiu_address;
  logic [BW-1:0]   mem_fiu_burstcount;
  logic [DW-1:0]   mem_fiu_writedata;
  logic [DW/8-1:0] mem_fiu_byteenable;
  logic            mem_fiu_read, mem_fiu_write, mem_fiu_waitrequest;
  logic [DW-1:0]   mem_fiu_readdata;
  logic            mem_fiu_readdatavalid;
  logic [AW-1:0]   mem_afu0_address, mem_afu1_address;
  logic [BW-1:0]   mem_afu0_burstcount, mem_afu1_burstcount;
  logic [DW-1:0]   mem_afu0_writedata, mem_afu1_writedata;
  logic [DW/8-1:0] mem_afu0_byteenable, mem_afu1_byteenable;
  logic            mem_afu0_read, mem_afu0_write, mem_afu0_waitrequest;
  logic            mem_afu1_read, mem_afu1_write, mem_afu1_waitrequest;
  logic [DW-1:0]   mem_afu0_readdata, mem_afu1_readdata;
  logic            mem_afu0_readdatavalid, mem_afu1_readdatavalid;

  avalon_mem_if_arb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW), .MAX_READS(MR)) dut (
    .clk(clk), .reset(reset),
    .mem_fiu_address(mem_fiu_address), .mem_fiu_burstcount(mem_fiu_burstcount),
    .mem_fiu_writedata(mem_fiu_writedata), .mem_fiu_byteenable(mem_fiu_byteenable),
    .mem_fiu_read(mem_fiu_read), .mem_fiu_write(mem_fiu_write),
    .mem_fiu_waitrequest(mem_fiu_waitrequest), .mem_fiu_readdata(mem_fiu_readdata),
    .mem_fiu_readdatavalid(mem_fiu_readdatavalid),
    .mem_afu0_address(mem_afu0_address), .mem_afu0_burstcount(mem_afu0_burstcount),
    .mem_afu0_writedata(mem_afu0_writedata), .mem_afu0_byteenable(mem_afu0_byteenable),
    .mem_afu0_read(mem_afu0_read), .mem_afu0_write(mem_afu0_write),
    .mem_afu0_waitrequest(mem_afu0_waitrequest), .mem_afu0_readdata(mem_afu0_readdata),
    .mem_afu0_readdatavalid(mem_afu0_readdatavalid),
    .mem_afu1_address(mem_afu1_address), .mem_afu1_burstcount(mem_afu1_burstcount),
    .mem_afu1_writedata(mem_afu1_writedata), .mem_afu1_byteenable(mem_afu1_byteenable),
    .mem_afu1_read(mem_afu1_read), .mem_afu1_write(mem_afu1_write),
    .mem_afu1_waitrequest(mem_afu1_waitrequest), .mem_afu1_readdata(mem_afu1_readdata),
    .mem_afu1_readdatavalid(mem_afu1_readdatavalid)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Requester command state: one command in flight per requester, held until accepted.
  bit            r_act  [2];
  bit            r_wr   [2];
  logic [AW-1:0] r_addr [2];
  logic [BW-1:0] r_bc   [2];
  int            r_beat [2];
  logic [DW-1:0] r_wd   [2];
  logic [3:0]    r_be   [2];
  int            auto_n [2];
  bit            auto_wr[2];
  logic [BW-1:0] auto_bc[2];
  bit            rand_mode;

  typedef struct { logic [DW-1:0] data; int due; } resp_t;
  logic [DW-1:0] mem [1024];
  resp_t         resp_q[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            out_q[$];
  int            wait_pct, rdv_pct, lat;
  bit            resp_hold;

  int n_acc[2];
  int n_rdv[2];
  int acc_ids[$];
  int rdv_ids[$];
  int last_acc_cyc[2];
  int first_rdv_cyc;

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input int i, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] bc);
    r_act[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a; r_bc[i] = bc; r_beat[i] = 0;
    r_wd[i] = $urandom; r_be[i] = 4'($urandom);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin n_acc[i] = 0; n_rdv[i] = 0; last_acc_cyc[i] = -1; end
    acc_ids.delete(); rdv_ids.delete(); first_rdv_cyc = -1;
  endtask

  function automatic bit idle();
    return !r_act[0] && !r_act[1] && auto_n[0] == 0 && auto_n[1] == 0 &&
           resp_q.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!r_act[i]) begin
        if (auto_n[i] > 0) begin
          auto_n[i]--;
          start(i, auto_wr[i], AW'($urandom), auto_bc[i]);
        end else if (rand_mode && int'($urandom_range(99)) < 40) begin
          start(i, 1'($urandom), AW'($urandom), BW'($urandom_range(4, 1)));
        end
      end
    end
    mem_afu0_read = r_act[0] & ~r_wr[0];  mem_afu0_write = r_act[0] & r_wr[0];
    mem_afu1_read = r_act[1] & ~r_wr[1];  mem_afu1_write = r_act[1] & r_wr[1];
    mem_afu0_address = r_addr[0]; mem_afu0_burstcount = r_bc[0];
    mem_afu0_writedata = r_wd[0]; mem_afu0_byteenable = r_be[0];
    mem_afu1_address = r_addr[1]; mem_afu1_burstcount = r_bc[1];
    mem_afu1_writedata = r_wd[1]; mem_afu1_byteenable = r_be[1];
    mem_fiu_waitrequest = (int'($urandom_range(99)) < wait_pct);
    if (!resp_hold && resp_q.size() > 0 && resp_q[0].due <= cyc_n &&
        int'($urandom_range(99)) < rdv_pct) begin
      mem_fiu_readdatavalid = 1'b1; mem_fiu_readdata = resp_q[0].data;
    end else begin
      mem_fiu_readdatavalid = 1'b0; mem_fiu_readdata = $urandom;
    end
  endtask

  task automatic observe();
    bit            acc[2];
    bit            facc;
    logic [AW-1:0] wa;
    if (reset) begin
      chk(mem_fiu_read | mem_fiu_write, 0, "rst_fiu_cmd");
      chk({mem_afu0_waitrequest, mem_afu1_waitrequest}, 2'b11, "rst_waitrequest");
      chk({mem_afu0_readdatavalid, mem_afu1_readdatavalid}, 2'b00, "rst_readdatavalid");
      return;
    end
    acc[0] = (mem_afu0_read | mem_afu0_write) & ~mem_afu0_waitrequest;
    acc[1] = (mem_afu1_read | mem_afu1_write) & ~mem_afu1_waitrequest;
    facc   = (mem_fiu_read | mem_fiu_write) & ~mem_fiu_waitrequest;
    chk(int'(acc[0]) + int'(acc[1]), int'(facc), "accept_pairing");
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        chk({mem_fiu_address, mem_fiu_burstcount, mem_fiu_write, mem_fiu_read},
            {r_addr[i], r_bc[i], r_wr[i], ~r_wr[i]}, i == 0 ? "fwd_cmd0" : "fwd_cmd1");
        if (r_wr[i]) chk({mem_fiu_writedata, mem_fiu_byteenable}, {r_wd[i], r_be[i]}, "fwd_wdata");
        chk(r_beat[1-i], 0, "burst_lock");
      end
    end
    chk(int'(mem_afu0_readdatavalid) + int'(mem_afu1_readdatavalid), int'(mem_fiu_readdatavalid), "rdv_pairing");
    if (mem_fiu_readdatavalid) begin
      chk(mem_afu0_readdata, mem_fiu_readdata, "rdata0_bcast");
      chk(mem_afu1_readdata, mem_fiu_readdata, "rdata1_bcast");
      if (first_rdv_cyc < 0) first_rdv_cyc = cyc_n;
    end
    if (mem_afu0_readdatavalid) begin
      chk(exp_q0.size() > 0, 1, "rdv0_expected");
      if (exp_q0.size() > 0) chk(mem_afu0_readdata, exp_q0.pop_front(), "rdata0");
      n_rdv[0]++; rdv_ids.push_back(0);
    end
    if (mem_afu1_readdatavalid) begin
      chk(exp_q1.size() > 0, 1, "rdv1_expected");
      if (exp_q1.size() > 0) chk(mem_afu1_readdata, exp_q1.pop_front(), "rdata1");
      n_rdv[1]++; rdv_ids.push_back(1);
    end
    if (mem_fiu_readdatavalid && resp_q.size() > 0) begin
      void'(resp_q.pop_front());
      if (out_q.size() > 0) begin
        out_q[0]--;
        if (out_q[0] == 0) void'(out_q.pop_front());
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        n_acc[i]++; acc_ids.push_back(i); last_acc_cyc[i] = cyc_n;
        if (r_wr[i]) begin
          wa = r_addr[i] + AW'(r_beat[i]);
          for (int b = 0; b < 4; b++) if (r_be[i][b]) mem[wa][8*b +: 8] = r_wd[i][8*b +: 8];
          if (r_beat[i] + 1 < int'(r_bc[i])) begin
            r_beat[i]++; r_wd[i] = $urandom; r_be[i] = 4'($urandom);
          end else begin
            r_act[i] = 1'b0; r_beat[i] = 0;
          end
        end else begin
          for (int k = 0; k < int'(r_bc[i]); k++) begin
            wa = r_addr[i] + AW'(k);
            resp_q.push_back('{mem[wa], cyc_n + lat + k});
            if (i == 0) exp_q0.push_back(mem[wa]); else exp_q1.push_back(mem[wa]);
          end
          out_q.push_back(int'(r_bc[i]));
          r_act[i] = 1'b0;
        end
      end
    end
    chk(out_q.size() <= MR, 1, "outstanding_limit");
  endtask

  task automatic cyc();
    drive();
    #3;
    observe();
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic run_until_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (idle()) break;
      cyc();
    end
    chk(idle(), 1, "drain_timeout");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    resp_q.delete(); exp_q0.delete(); exp_q1.delete(); out_q.delete();
    cyc(); cyc();
    for (int i = 0; i < 2; i++) begin r_act[i] = 1'b0; r_beat[i] = 0; auto_n[i] = 0; end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      r_act[i] = 0; r_wr[i] = 0; r_addr[i] = '0; r_bc[i] = 4'd1; r_beat[i] = 0;
      r_wd[i] = '0; r_be[i] = '1; auto_n[i] = 0; auto_wr[i] = 0; auto_bc[i] = 4'd1;
    end
    rand_mode = 0; wait_pct = 0; rdv_pct = 100; lat = 3; resp_hold = 0;
    clear_stats();
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset gating with both requesters asserting commands
    start(0, 1'b0, 10'h020, 4'd2);
    start(1, 1'b1, 10'h030, 4'd3);
    do_reset();

    // Single read burst from requester 0
    clear_stats();
    start(0, 1'b0, 10'h010, 4'd4);
    run_until_idle(200);
    chk(n_acc[0], 1, "t1_acc0");
    chk(n_acc[1], 0, "t1_acc1");
    chk(n_rdv[0], 4, "t1_rdv0");
    chk(n_rdv[1], 0, "t1_rdv1");

    // Continuous single-beat writes from both: strict alternation starting at 0
    do_reset();
    clear_stats();
    auto_n[0] = 4; auto_n[1] = 4; auto_wr[0] = 1; auto_wr[1] = 1; auto_bc[0] = 4'd1; auto_bc[1] = 4'd1;
    for (int k = 0; k < 8; k++) cyc();
    chk(acc_ids.size(), 8, "t2_count");
    for (int k = 0; k < acc_ids.size() && k < 8; k++) chk(acc_ids[k], k % 2, "t2_alternate");
    run_until_idle(50);

    // Write burst of 4 locks out a concurrent read
    clear_stats();
    start(0, 1'b1, 10'h100, 4'd4);
    start(1, 1'b0, 10'h100, 4'd2);
    run_until_idle(200);
    chk(acc_ids.size(), 5, "t3_count");
    for (int k = 0; k < acc_ids.size() && k < 5; k++) chk(acc_ids[k], k == 4 ? 1 : 0, "t3_order");
    chk(last_acc_cyc[1], last_acc_cyc[0] + 1, "t3_read_next_cycle");

    // Interleaved reads with long memory latency
    clear_stats();
    lat = 10;
    start(0, 1'b0, 10'h200, 4'd2);
    start(1, 1'b0, 10'h300, 4'd3);
    run_until_idle(200);
    chk(rdv_ids.size(), 5, "t4_rdv_count");
    for (int k = 0; k < rdv_ids.size() && k < 5; k++) chk(rdv_ids[k], k < 2 ? 0 : 1, "t4_rdv_route");
    lat = 3;

    // Tag FIFO full blocks the 17th read until the first response completes
    clear_stats();
    resp_hold = 1;
    auto_n[0] = 17; auto_wr[0] = 0; auto_bc[0] = 4'd1;
    for (int k = 0; k < 30; k++) cyc();
    chk(n_acc[0], 16, "t5_accepted_while_full");
    chk(mem_afu0_waitrequest, 1, "t5_17th_waits");
    resp_hold = 0;
    run_until_idle(300);
    chk(n_acc[0], 17, "t5_all_accepted");
    chk(last_acc_cyc[0] > first_rdv_cyc, 1, "t5_release_after_response");

    // Reset in the middle of a write burst with two beats left
    clear_stats();
    start(1, 1'b1, 10'h3F0, 4'd4);
    for (int k = 0; k < 20 && r_beat[1] != 2; k++) cyc();
    chk(r_beat[1], 2, "t6_burst_progress");
    start(0, 1'b1, 10'h050, 4'd1);
    do_reset();
    clear_stats();
    start(0, 1'b1, 10'h060, 4'd1);
    start(1, 1'b1, 10'h070, 4'd1);
    run_until_idle(50);
    chk(acc_ids.size() > 0 ? acc_ids[0] : -1, 0, "t6_first_tie_after_reset");

    // Random traffic with memory stalls and response gaps
    clear_stats();
    rand_mode = 1; wait_pct = 25; rdv_pct = 70;
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) lat = int'($urandom_range(8, 1));
      cyc();
    end
    rand_mode = 0;
    run_until_idle(2000);
    chk(n_acc[0] > 0 && n_acc[1] > 0, 1, "rand_both_active");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_mem_if_arb2.md
# avalon_mem_if_arb2

Two-way arbiter that shares one Avalon-MM local-memory port between two AFU-side requesters. Sits between the platform's local-memory interface (optionally behind register stages) and two independent AFU engines. Grants commands round-robin at burst boundaries, locks the grant for the full length of a write burst, and routes read responses back to the issuing requester via an in-order tag FIFO.

## Interface
Parameters:
- DATA_WIDTH, 32, readdata/writedata width
- ADDR_WIDTH, 10, word address width
- BURST_CNT_WIDTH, 4, burstcount width
- MAX_READS, 16, read commands outstanding at the memory (tag FIFO depth, power of 2)

Ports:
- clk  in  1  sole clock; all interfaces are synchronous to it
- reset  in  1  synchronous, active-high
- mem_fiu  avalon_mem_if.to_fiu  interface  shared downstream memory port
- mem_afu0  avalon_mem_if.to_afu  interface  requester 0
- mem_afu1  avalon_mem_if.to_afu  interface  requester 1

## Operation
- Command accepted on a port when (read|write) && !waitrequest. burstcount 0 is illegal.
- State: GRANT_ARB, WR_LOCK. Registers: owner (1b), last (1b), beats_left (BURST_CNT_WIDTH).
- GRANT_ARB: candidates = requesters with read or write asserted; requester 1 is read-blocked if tag FIFO full (same for 0). One candidate -> granted; both -> the one != last. Granted requester's address/burstcount/writedata/byteenable/read/write pass combinationally to mem_fiu.
- Granted write beat accepted with burstcount > 1 -> WR_LOCK, owner = granted, beats_left = burstcount-1. Accepted read or single-beat write stays in GRANT_ARB. Every accepted command start sets last = granted.
- WR_LOCK: only owner forwarded; non-owner waitrequest=1. Each accepted write beat decrements beats_left; accept at beats_left==1 -> GRANT_ARB. Owner read asserted in WR_LOCK is a protocol error (assertion), not forwarded.
- Waitrequest to a requester = !granted | mem_fiu.waitrequest | (read && fifo_full). Non-granted requester sees waitrequest=1.
- Read routing: accepted read pushes {id, burstcount} into tag FIFO. readdata broadcast to both requesters; readdatavalid asserted only on the port matching FIFO head id. Beat counter increments per mem_fiu.readdatavalid; on beat == head burstcount, pop and reset counter to 0.
- Push and pop in same cycle allowed; fifo_full computed from registered occupancy (no bypass credit).
- mem_fiu.readdatavalid with FIFO empty: simulation assertion; beat dropped.

## Timing
- Reset: state GRANT_ARB, last=1 (requester 0 wins first tie), beats_left=0, FIFO empty, beat counter 0. While reset high: mem_fiu.read=write=0, both requester waitrequest=1, both readdatavalid=0.
- Command path: zero added latency (combinational mux, arbitration from current requests + registered state).
- Response path: zero added latency; readdatavalid to requester in same cycle as mem_fiu.readdatavalid.
- Grant switches in the cycle after the final beat of a write burst at earliest; back-to-back reads from alternating requesters may be issued in consecutive cycles.
- Requesters must hold command stable while waitrequest=1 (Avalon rule); arbiter does not change grant while the granted command is stalled by mem_fiu.waitrequest.
- Reset mid-burst or with reads in flight: all state cleared; in-flight responses after reset are undefined (memory reset alongside).

## Test plan
- Single requester 0 reads addr 0x10 burst 4 -> one mem_fiu read, 4 readdatavalid on afu0 only, afu1 readdatavalid stays 0.
- Both assert single-beat writes every cycle for 8 cycles, mem_fiu.waitrequest=0 -> grants alternate 0,1,0,1...; 4 writes each.
- afu0 write burst 4, afu1 read asserted during it -> 4 consecutive afu0 beats on mem_fiu, afu1 read forwarded in the next cycle.
- Interleaved reads afu0 burst 2, afu1 burst 3, memory returns 5 beats with 10-cycle latency -> first 2 beats to afu0, next 3 to afu1, FIFO empty after.
- afu0 issues MAX_READS=16 reads with memory stalled on responses -> 17th read sees waitrequest=1 until first read's final beat returns.
- Assert reset during afu1 write burst (beats_left=2) -> next cycle mem_fiu.write=0, both waitrequest=1; after release afu0 wins first tie.
